// File: rtl/sd_reg_arb_pkg.sv
// Shared types and limits for the SD controller register-port arbiter.
package sd_reg_arb_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_e;

   typedef logic arb_owner_t;

   localparam int RD_LAT_MAX = 7;
   localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/define.sv
// Global width settings shared by the SD slave register path.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: lone requester wins, ptr breaks a tie.
module rr_pick2
   import sd_reg_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output arb_owner_t owner,
   output logic       any
);

   assign any   = |req;
   assign owner = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/sd_reg_arbiter.sv
// Shares the sd_host_controller register port between the CPU bridge (m0)
// and the boot/DMA sequencer (m1), one transaction at a time.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sd_reg_arbiter
   import sd_reg_arb_pkg::*;
#(
   parameter int ADDR_W = `ADDR_WIDTH,
   parameter int DATA_W = `DATA_WIDTH,
   parameter int RD_LAT = 1
)
(
   input  logic                clk_i,
   input  logic                rst_i,

   input  logic                m0_req,
   input  logic                m0_write,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_strb,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,

   input  logic                m1_req,
   input  logic                m1_write,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_strb,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,

   output logic                sd_we,
   output logic [ADDR_W-1:0]   sd_waddr,
   output logic [DATA_W-1:0]   sd_wdata,
   output logic [DATA_W/8-1:0] sd_strb,
   output logic                sd_re,
   output logic [ADDR_W-1:0]   sd_raddr,
   input  logic [DATA_W-1:0]   sd_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

   arb_state_e        state;
   logic              ptr;
   arb_owner_t        own;
   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [STRB_W-1:0] lat_strb;
   logic [CNT_W-1:0]  cnt;

   arb_owner_t        pick_owner;
   logic              pick_any;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_strb;

   rr_pick2 u_pick (
      .req   ({m1_req, m0_req}),
      .ptr   (ptr),
      .owner (pick_owner),
      .any   (pick_any)
   );

   assign sel_write = pick_owner ? m1_write : m0_write;
   assign sel_addr  = pick_owner ? m1_addr  : m0_addr;
   assign sel_wdata = pick_owner ? m1_wdata : m0_wdata;
   assign sel_strb  = pick_owner ? m1_strb  : m0_strb;

   // The controller port is driven straight from the latched request, so it is
   // stable for the whole issue cycle; strobes are masked off for reads.
   assign sd_waddr = lat_addr;
   assign sd_raddr = lat_addr;
   assign sd_wdata = lat_wdata;
   assign sd_strb  = lat_write ? lat_strb : '0;

   // Pulses are set on the edge entering their state and cleared by default,
   // which keeps every control output registered and exactly one cycle wide.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         ptr       <= 1'b0;
         own       <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_strb  <= '0;
         cnt       <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         sd_we     <= 1'b0;
         sd_re     <= 1'b0;
      end else begin
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         sd_we     <= 1'b0;
         sd_re     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  own       <= pick_owner;
                  lat_write <= sel_write;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
                  lat_strb  <= sel_strb;
                  sd_we     <= sel_write;
                  sd_re     <= ~sel_write;
                  m0_gnt    <= ~pick_owner;
                  m1_gnt    <= pick_owner;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               ptr <= ~own;
               if (lat_write) begin
                  state <= S_IDLE;
               end else begin
                  cnt   <= LAT_LOAD;
                  state <= S_WAIT;
               end
            end
            // Counter reaches zero in the cycle the controller presents read data.
            S_WAIT: begin
               if (cnt == '0) begin
                  if (own) begin
                     m1_rdata  <= sd_rdata;
                     m1_rvalid <= 1'b1;
                  end else begin
                     m0_rdata  <= sd_rdata;
                     m0_rvalid <= 1'b1;
                  end
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Self-checking bench for sd_reg_arbiter: directed scenarios plus random single
// transactions, checked against a register-file model of the controller.
module tb_sd_reg_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int LAT = 3;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_req, m0_write, m1_req, m1_write;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [SW-1:0] m0_strb, m1_strb;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          sd_we, sd_re;
   logic [AW-1:0] sd_waddr, sd_raddr;
   logic [DW-1:0] sd_wdata, sd_rdata;
   logic [SW-1:0] sd_strb;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] ref_mem  [256];
   logic [DW-1:0] ctrl_mem [256];
   logic [DW-1:0] exp_rdata [2];
   logic          last_owner;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } resp_t;
   resp_t rq[$];

   logic          first, own;
   logic [7:0]    pa  [2][4];
   logic [DW-1:0] pay [2][4];
   int            idx [2];
   bit            upd [2];
   logic [7:0]    ra;
   logic [DW-1:0] rd;
   logic [SW-1:0] rs;
   bit            rm, rw;

   sd_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_strb(m0_strb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_strb(m1_strb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .sd_we(sd_we), .sd_waddr(sd_waddr), .sd_wdata(sd_wdata), .sd_strb(sd_strb),
      .sd_re(sd_re), .sd_raddr(sd_raddr), .sd_rdata(sd_rdata)
   );

   initial forever #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [SW-1:0] s);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic checkv(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input bit m, input bit r, input bit wr, input logic [7:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
      if (m) begin
         m1_req = r; m1_write = wr; m1_addr = {24'b0, a}; m1_wdata = d; m1_strb = s;
      end else begin
         m0_req = r; m0_write = wr; m0_addr = {24'b0, a}; m0_wdata = d; m0_strb = s;
      end
   endtask

   // Register-file model of the controller: applies writes, answers reads LAT cycles later.
   initial begin
      resp_t e;
      sd_rdata = '0;
      forever begin
         @(negedge clk_i);
         checkv("we_re_exclusive", DW'(sd_we & sd_re), '0);
         if (sd_we === 1'b1)
            ctrl_mem[sd_waddr[7:0]] = merge(ctrl_mem[sd_waddr[7:0]], sd_wdata, sd_strb);
         if (sd_re === 1'b1) begin
            e.due  = cyc + LAT;
            e.data = ctrl_mem[sd_raddr[7:0]];
            rq.push_back(e);
         end
         while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
         if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            sd_rdata = e.data;
         end else begin
            sd_rdata = $urandom;
         end
      end
   end

   // One isolated transaction from requester m, starting with the DUT idle.
   task automatic applyStimulus(input bit m, input bit wr, input logic [7:0] a,
                                input logic [DW-1:0] d, input logic [SW-1:0] s);
      logic [DW-1:0] exp;
      drive_req(m, 1'b1, wr, a, d, s);
      @(negedge clk_i);
      checkv("idle_no_gnt", {m1_gnt, m0_gnt}, '0);
      tick();
      @(negedge clk_i);
      checkv("gnt_owner", {m1_gnt, m0_gnt}, m ? 2 : 1);
      checkv("sd_we", sd_we, wr);
      checkv("sd_re", sd_re, !wr);
      if (wr) begin
         checkv("sd_waddr", sd_waddr, {24'b0, a});
         checkv("sd_wdata", sd_wdata, d);
         checkv("sd_strb", sd_strb, s);
         ref_mem[a] = merge(ref_mem[a], d, s);
      end else begin
         checkv("sd_raddr", sd_raddr, {24'b0, a});
         checkv("sd_strb_read", sd_strb, '0);
      end
      exp = ref_mem[a];
      tick();
      drive_req(m, 1'b0, wr, a, d, s);
      if (!wr) begin
         for (int c = 2; c <= 1 + LAT; c++) begin
            @(negedge clk_i);
            checkv("rvalid_early", {m1_rvalid, m0_rvalid}, '0);
            checkv("gnt_in_wait", {m1_gnt, m0_gnt}, '0);
            tick();
         end
         checkOutput(m, exp);
         tick();
      end
      last_owner = m;
   endtask

   task automatic checkOutput(input bit m, input logic [DW-1:0] exp);
      @(negedge clk_i);
      checkv("rvalid_owner", {m1_rvalid, m0_rvalid}, m ? 2 : 1);
      checkv("rdata_owner", m ? m1_rdata : m0_rdata, exp);
      exp_rdata[m] = exp;
      checkv("rdata_other", m ? m0_rdata : m1_rdata, exp_rdata[!m]);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rd = $urandom;
         ref_mem[i]  = rd;
         ctrl_mem[i] = rd;
      end
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;

      // Reset held with both requesting; first grant goes to m0.
      rst_i = 1'b1;
      pay[0][0] = $urandom;
      pay[1][0] = $urandom;
      drive_req(1'b0, 1'b1, 1'b1, 8'h04, pay[0][0], 4'hF);
      drive_req(1'b1, 1'b1, 1'b1, 8'h0C, pay[1][0], 4'h5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checkv("reset_outputs", DW'(|{m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                                      sd_we, sd_re, sd_waddr, sd_wdata, sd_strb, sd_raddr}), '0);
      end
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      checkv("release_no_gnt", {m1_gnt, m0_gnt, sd_we}, '0);
      tick();
      @(negedge clk_i);
      checkv("first_gnt_m0", {m1_gnt, m0_gnt}, 1);
      checkv("first_waddr", sd_waddr, 32'h04);
      checkv("first_wdata", sd_wdata, pay[0][0]);
      ref_mem[8'h04] = merge(ref_mem[8'h04], pay[0][0], 4'hF);
      tick();
      m0_req = 1'b0;
      @(negedge clk_i);
      checkv("gap_no_gnt", {m1_gnt, m0_gnt}, '0);
      tick();
      @(negedge clk_i);
      checkv("second_gnt_m1", {m1_gnt, m0_gnt}, 2);
      checkv("second_waddr", sd_waddr, 32'h0C);
      checkv("second_strb", sd_strb, 4'h5);
      ref_mem[8'h0C] = merge(ref_mem[8'h0C], pay[1][0], 4'h5);
      tick();
      m1_req = 1'b0;
      last_owner = 1'b1;

      // Directed write and read.
      applyStimulus(1'b0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF);
      ref_mem[8'h10]  = 32'h1234_5678;
      ctrl_mem[8'h10] = 32'h1234_5678;
      applyStimulus(1'b1, 1'b0, 8'h10, '0, '0);

      // Both requesters hold four writes each: strict alternation.
      first = ~last_owner;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            pa[r][i]  = 8'h80 + 8'(r * 32) + 8'(i * 4);
            pay[r][i] = $urandom;
         end
         idx[r] = 0;
         upd[r] = 1'b0;
         drive_req(r[0], 1'b1, 1'b1, pa[r][0], pay[r][0], 4'hF);
      end
      for (int c = 1; c <= 16; c++) begin
         tick();
         for (int r = 0; r < 2; r++) begin
            if (upd[r]) begin
               upd[r] = 1'b0;
               if (idx[r] < 4) drive_req(r[0], 1'b1, 1'b1, pa[r][idx[r]], pay[r][idx[r]], 4'hF);
               else drive_req(r[0], 1'b0, 1'b1, 8'h00, '0, '0);
            end
         end
         @(negedge clk_i);
         if (c % 2 == 1) begin
            own = first ^ 1'(((c - 1) / 2) % 2);
            checkv("alt_gnt", {m1_gnt, m0_gnt}, own ? 2 : 1);
            checkv("alt_waddr", sd_waddr, {24'b0, pa[own][idx[own]]});
            checkv("alt_wdata", sd_wdata, pay[own][idx[own]]);
            ref_mem[pa[own][idx[own]]] = pay[own][idx[own]];
            idx[own]++;
            upd[own] = 1'b1;
         end else begin
            checkv("alt_gap", {m1_gnt, m0_gnt}, '0);
         end
      end
      tick();
      m0_req = 1'b0;
      m1_req = 1'b0;
      last_owner = ~first;

      // Reset one cycle after a read issues: read discarded, rdata cleared.
      drive_req(1'b0, 1'b1, 1'b0, 8'h24, '0, '0);
      tick();
      @(negedge clk_i);
      checkv("rst_read_issue", {sd_re, m0_gnt}, 2'b11);
      tick();
      m0_req = 1'b0;
      rst_i  = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int c = 3; c <= 8; c++) begin
         @(negedge clk_i);
         checkv("rst_no_rvalid", {m1_rvalid, m0_rvalid, sd_we, sd_re}, '0);
         checkv("rst_rdata_clear", m0_rdata | m1_rdata, '0);
         tick();
      end
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      applyStimulus(1'b0, 1'b0, 8'h24, '0, '0);
      applyStimulus(1'b1, 1'b1, 8'h28, 32'hCAFE_F00D, 4'h3);

      // m1 drops req in its grant cycle: write still issues exactly once.
      rd = $urandom;
      drive_req(1'b1, 1'b1, 1'b1, 8'h30, rd, 4'hC);
      tick();
      m1_req = 1'b0;
      @(negedge clk_i);
      checkv("drop_gnt", {m1_gnt, m0_gnt, sd_we}, 3'b101);
      checkv("drop_wdata", sd_wdata, rd);
      ref_mem[8'h30] = merge(ref_mem[8'h30], rd, 4'hC);
      for (int c = 2; c <= 4; c++) begin
         tick();
         @(negedge clk_i);
         checkv("drop_once", {m1_gnt, m0_gnt, sd_we, sd_re}, '0);
      end
      tick();
      last_owner = 1'b1;

      // Random isolated transactions, reads checked against the reference register file.
      for (int n = 0; n < 40; n++) begin
         rm = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         ra = 8'($urandom_range(0, 63)) << 2;
         rd = $urandom;
         rs = SW'($urandom_range(1, 15));
         applyStimulus(rm, rw, ra, rd, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
